// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out converter with valid/ready handshakes on both
// sides. A word is captured in IDLE, then emitted MSB first, one bit per
// accepted beat. The downstream side may stall at any beat; the beat is held
// stable until it is accepted.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When defined, every word is followed by one extra even-parity beat
//   (XOR of all data bits). In that build ser_last marks the parity beat
//   instead of the LSB beat.
//
// Parameters:
//   WIDTH      parallel word width, 2..32
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   load_valid upstream presents a word on load_data
//   load_data  parallel word (WIDTH bits)
//   load_ready block accepts a word this cycle (high only in IDLE)
//   ser_out    serial data bit
//   ser_valid  ser_out carries a valid beat
//   ser_last   final beat of the current word
//   ser_ready  downstream consumes the current beat
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  // Index counter width; WIDTH >= 2 guarantees at least one bit.
  localparam int IW = $clog2(WIDTH);

  localparam logic [IW-1:0] IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ZERO = '0;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] ST_PARITY = 2'd2;
`endif

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Index-driven WIDTH:1 selector. Written as an explicit compare-and-pick
  // loop so the mux is fully defined even when WIDTH is not a power of two
  // (unreachable index codes simply select 0).
  function automatic logic sel_bit(input logic [WIDTH-1:0] word,
                                   input logic [IW-1:0]    idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == IW'(i)) begin
        b = word[i];
      end
    end
    return b;
  endfunction

`ifdef PISO_PARITY_EN
  // Even parity: the extra bit makes the total number of ones even.
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] held_q,  held_d;
  logic [IW-1:0]    idx_q,   idx_d;

  logic load_fire;
  logic beat_fire;

  assign load_fire = load_valid && load_ready;
  assign beat_fire = ser_valid && ser_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          held_d  = load_data;
          idx_d   = IDX_TOP;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Nothing moves while the beat is stalled; the held word and index
        // only change on an accepted beat.
        if (beat_fire) begin
          if (idx_q != IDX_ZERO) begin
            idx_d = idx_q - IDX_ONE;
          end else begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end

`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (beat_fire) begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers (reset wins over any handshake in the same cycle)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      idx_q   <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (pure decode of registered state, no input-to-output paths
  // except through the handshake qualifiers above)
  // ---------------------------------------------------------------------------
  always_comb begin
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    ser_out    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
      end

      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = sel_bit(held_q, idx_q);
`ifdef PISO_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = (idx_q == IDX_ZERO);
`endif
      end

`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        ser_out   = even_parity(held_q);
      end
`endif

      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int PERIOD = W + 1 + (PAR ? 1 : 0);

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_ready;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Scoreboard entries are {ser_out, ser_last}.
  logic [1:0] exp_q[$];

  // Reference model of the beats produced for one word.
  task automatic push_word(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back({d[i], (i == 0) && !PAR});
    end
    if (PAR) exp_q.push_back({^d, 1'b1});
  endtask

  // Present a word at a negedge while idle; returns at the next negedge,
  // where the first beat is already visible.
  task automatic load_word(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    push_word(d);
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b want=1", load_ready); else n_pass++;
    n_total++; if (ser_valid !== 1'b0) $display("FAIL reset_ser_valid got=%b want=0", ser_valid); else n_pass++;
    n_total++; if (ser_last !== 1'b0) $display("FAIL reset_ser_last got=%b want=0", ser_last); else n_pass++;
    n_total++; if (ser_out !== 1'b0) $display("FAIL reset_ser_out got=%b want=0", ser_out); else n_pass++;
  endtask

  task automatic test_basic(input logic [W-1:0] d, input string nm);
    int cyc;
    logic [1:0] ex;
    ser_ready = 1'b1;
    load_word(d);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      n_total++; if (ser_valid !== 1'b1) $display("FAIL %s_valid cyc=%0d got=%b want=1", nm, cyc, ser_valid); else n_pass++;
      n_total++; if (load_ready !== 1'b0) $display("FAIL %s_busy cyc=%0d got=%b want=0", nm, cyc, load_ready); else n_pass++;
      if (ser_valid === 1'b1) begin
        ex = exp_q.pop_front();
        n_total++;
        if ({ser_out, ser_last} !== ex)
          $display("FAIL %s_beat cyc=%0d got out/last=%b%b want=%b%b", nm, cyc, ser_out, ser_last, ex[1], ex[0]);
        else n_pass++;
      end
      @(negedge clk); cyc++;
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL %s_timeout left=%0d want=0", nm, exp_q.size()); else n_pass++;
    exp_q.delete();
    n_total++; if (load_ready !== 1'b1) $display("FAIL %s_ready_after got=%b want=1", nm, load_ready); else n_pass++;
    n_total++; if (ser_valid !== 1'b0) $display("FAIL %s_idle_after got=%b want=0", nm, ser_valid); else n_pass++;
  endtask

  task automatic test_stall();
    int cyc, b, stall, held0;
    logic [1:0] ex;
    ser_ready = 1'b1;
    load_word(8'hC3);
    cyc = 0; b = 0; stall = 0; held0 = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      n_total++; if (ser_valid !== 1'b1) $display("FAIL stall_valid cyc=%0d got=%b want=1", cyc, ser_valid); else n_pass++;
      ex = exp_q[0];
      n_total++;
      if ({ser_out, ser_last} !== ex)
        $display("FAIL stall_beat cyc=%0d got out/last=%b%b want=%b%b", cyc, ser_out, ser_last, ex[1], ex[0]);
      else n_pass++;
      if (b == 3 && ser_out === 1'b0) held0++;
      if (b == 3 && stall < 3) begin
        ser_ready = 1'b0;
        stall++;
      end else begin
        ser_ready = 1'b1;
        if (ser_valid === 1'b1) begin
          void'(exp_q.pop_front());
          b++;
        end
      end
      @(negedge clk); cyc++;
    end
    n_total++; if (exp_q.size() != 0) $display("FAIL stall_timeout left=%0d want=0", exp_q.size()); else n_pass++;
    exp_q.delete();
    n_total++; if (held0 != 4) $display("FAIL stall_hold_cycles got=%0d want=4", held0); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL stall_ready_after got=%b want=1", load_ready); else n_pass++;
  endtask

  task automatic test_busy_load();
    int cyc, b;
    logic [1:0] ex;
    ser_ready = 1'b1;
    load_word(8'hF0);
    cyc = 0; b = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      load_valid = 1'b0;
      n_total++; if (ser_valid !== 1'b1) $display("FAIL busy_valid cyc=%0d got=%b want=1", cyc, ser_valid); else n_pass++;
      if (ser_valid === 1'b1) begin
        ex = exp_q.pop_front();
        n_total++;
        if ({ser_out, ser_last} !== ex)
          $display("FAIL busy_beat cyc=%0d got out/last=%b%b want=%b%b", cyc, ser_out, ser_last, ex[1], ex[0]);
        else n_pass++;
        b++;
        if (b == 2) begin
          n_total++; if (load_ready !== 1'b0) $display("FAIL busy_load_ready got=%b want=0", load_ready); else n_pass++;
          load_valid = 1'b1;
          load_data  = 8'h0F;
        end
      end
      @(negedge clk); cyc++;
    end
    load_valid = 1'b0;
    n_total++; if (exp_q.size() != 0) $display("FAIL busy_timeout left=%0d want=0", exp_q.size()); else n_pass++;
    exp_q.delete();
    // The ignored word must not appear afterwards.
    repeat (3) begin
      n_total++; if (ser_valid !== 1'b0) $display("FAIL busy_no_queue got=%b want=0", ser_valid); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_midword_reset();
    logic [1:0] ex;
    ser_ready = 1'b1;
    load_word(8'hFF);
    for (int c = 0; c < 3; c++) begin
      n_total++; if (ser_valid !== 1'b1) $display("FAIL mrst_valid cyc=%0d got=%b want=1", c, ser_valid); else n_pass++;
      ex = exp_q.pop_front();
      n_total++;
      if ({ser_out, ser_last} !== ex)
        $display("FAIL mrst_beat cyc=%0d got out/last=%b%b want=%b%b", c, ser_out, ser_last, ex[1], ex[0]);
      else n_pass++;
      if (c == 2) rst_n = 1'b0;
      @(negedge clk);
    end
    exp_q.delete();
    rst_n = 1'b1;
    n_total++; if (ser_valid !== 1'b0) $display("FAIL mrst_valid_after got=%b want=0", ser_valid); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL mrst_ready_after got=%b want=1", load_ready); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++;
      if (ser_valid !== 1'b0 || ser_last !== 1'b0)
        $display("FAIL mrst_quiet cyc=%0d got valid/last=%b%b want=00", c, ser_valid, ser_last);
      else n_pass++;
    end
  endtask

  task automatic test_reset_precedence();
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    rst_n      = 1'b0;
    @(negedge clk);
    load_valid = 1'b0;
    rst_n      = 1'b1;
    n_total++; if (ser_valid !== 1'b0) $display("FAIL rprec_valid got=%b want=0", ser_valid); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL rprec_ready got=%b want=1", load_ready); else n_pass++;
    @(negedge clk);
    n_total++; if (ser_valid !== 1'b0) $display("FAIL rprec_valid2 got=%b want=0", ser_valid); else n_pass++;
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words [2];
    logic         pbit  [2];
    int cyc, b;
    logic [1:0] ex;
    words[0] = 8'hA5; pbit[0] = 1'b0;
    words[1] = 8'h07; pbit[1] = 1'b1;
    ser_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_word(words[k]);
      cyc = 0; b = 0;
      while (exp_q.size() > 0 && cyc < 40) begin
        if (ser_valid === 1'b1) begin
          ex = exp_q.pop_front();
          n_total++;
          if ({ser_out, ser_last} !== ex)
            $display("FAIL par_beat k=%0d cyc=%0d got out/last=%b%b want=%b%b", k, cyc, ser_out, ser_last, ex[1], ex[0]);
          else n_pass++;
          b++;
          if (b == W + 1) begin
            n_total++;
            if (ser_out !== pbit[k] || ser_last !== 1'b1)
              $display("FAIL par_bit k=%0d got out/last=%b%b want=%b1", k, ser_out, ser_last, pbit[k]);
            else n_pass++;
          end
        end
        @(negedge clk); cyc++;
      end
      n_total++; if (b != W + 1) $display("FAIL par_beats k=%0d got=%0d want=%0d", k, b, W + 1); else n_pass++;
      exp_q.delete();
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int hs [3];
    int cyc, k;
    logic [1:0] ex;
    words[0] = 8'h3C; words[1] = 8'h81; words[2] = 8'h5A;
    k = 0; cyc = 0;
    ser_ready  = 1'b1;
    load_valid = 1'b1;
    while ((k < 3 || exp_q.size() > 0) && cyc < 100) begin
      if (ser_valid === 1'b1) begin
        if (exp_q.size() > 0) begin
          ex = exp_q.pop_front();
          n_total++;
          if ({ser_out, ser_last} !== ex)
            $display("FAIL b2b_beat cyc=%0d got out/last=%b%b want=%b%b", cyc, ser_out, ser_last, ex[1], ex[0]);
          else n_pass++;
        end else begin
          n_total++;
          $display("FAIL b2b_extra_beat cyc=%0d got valid=1 want=0", cyc);
        end
      end
      if (k < 3 && load_ready === 1'b1) begin
        load_data = words[k];
        push_word(words[k]);
        hs[k] = cyc;
        k++;
      end else if (k == 3) begin
        load_valid = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    load_valid = 1'b0;
    n_total++; if (k != 3 || exp_q.size() != 0) $display("FAIL b2b_timeout loaded=%0d left=%0d want=3/0", k, exp_q.size()); else n_pass++;
    exp_q.delete();
    if (k == 3) begin
      n_total++; if (hs[1] - hs[0] != PERIOD) $display("FAIL b2b_period0 got=%0d want=%0d", hs[1] - hs[0], PERIOD); else n_pass++;
      n_total++; if (hs[2] - hs[1] != PERIOD) $display("FAIL b2b_period1 got=%0d want=%0d", hs[2] - hs[1], PERIOD); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; ser_ready = 1'b0;
    test_reset();
    test_basic(8'hA5, "basic_a5");
    test_basic(8'h01, "basic_01");
    test_stall();
    test_busy_load();
    test_midword_reset();
    test_reset_precedence();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
